// File: rtl/vend_pkg.sv
// Shared encodings for the change dispenser: FSM states, coin_sel codes and coin values.
package vend_pkg;

   localparam int unsigned REM_W = 3;
   localparam int unsigned SEL_W = 2;
   localparam int unsigned ST_W  = 3;

   typedef enum logic [ST_W-1:0] {
      IDLE = 3'd0,
      SEL  = 3'd1,
      REQ  = 3'd2,
      DONE = 3'd3
   } state_t;

   localparam logic [SEL_W-1:0] COIN_NONE = 2'b00;
   localparam logic [SEL_W-1:0] COIN_1    = 2'b01;
   localparam logic [SEL_W-1:0] COIN_2    = 2'b10;
   localparam logic [SEL_W-1:0] COIN_5    = 2'b11;

   localparam logic [REM_W-1:0] VAL_1 = 3'd1;
   localparam logic [REM_W-1:0] VAL_2 = 3'd2;
   localparam logic [REM_W-1:0] VAL_5 = 3'd5;

   // Dollar value of a coin_sel code; COIN_NONE is worth nothing.
   function automatic logic [REM_W-1:0] coin_value(input logic [SEL_W-1:0] sel);
      case (sel)
         COIN_1:  return VAL_1;
         COIN_2:  return VAL_2;
         COIN_5:  return VAL_5;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/change_select.sv
// Combinational coin picker: largest available coin not exceeding rem.
// $5 payout only when CHANGE_DISPENSER_FIVE_COIN_EN is defined.
module change_select
   import vend_pkg::*;
(
   input  logic [REM_W-1:0] rem,
   input  logic             two_empty,
   input  logic             five_empty,
   output logic [SEL_W-1:0] coin_sel
);

   logic five_ok;

`ifdef CHANGE_DISPENSER_FIVE_COIN_EN
   assign five_ok = (rem >= VAL_5) && !five_empty;
`else
   logic unused_five;
   assign five_ok     = 1'b0;
   assign unused_five = five_empty;
`endif

   // $1 is the fallback, so the chosen value never exceeds a nonzero rem.
   always_comb begin
      coin_sel = COIN_1;
      if (five_ok) begin
         coin_sel = COIN_5;
      end else if ((rem >= VAL_2) && !two_empty) begin
         coin_sel = COIN_2;
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Change payout FSM: latches the amount owed and requests coins from the hopper one at a time.
// Build option: CHANGE_DISPENSER_FIVE_COIN_EN enables $5 coins (see change_select).
module change_dispenser
   import vend_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             d,
   input  logic [REM_W-1:0] r,
   input  logic             coin_ack,
   input  logic             two_empty,
   input  logic             five_empty,
   output logic             coin_req,
   output logic [SEL_W-1:0] coin_sel,
   output logic             busy,
   output logic             done,
   output logic             dropped,
   output logic [REM_W-1:0] rem,
   output logic [ST_W-1:0]  state
);

   state_t           st;
   logic [SEL_W-1:0] pick_c;
   logic [REM_W-1:0] rem_next_c;

   change_select u_select (
      .rem        (rem),
      .two_empty  (two_empty),
      .five_empty (five_empty),
      .coin_sel   (pick_c)
   );

   assign rem_next_c = REM_W'(rem - coin_value(coin_sel));
   assign state      = st;

   // Flags are sampled only in SEL; the pending coin is frozen in coin_sel through REQ.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st       <= IDLE;
         rem      <= '0;
         coin_req <= 1'b0;
         coin_sel <= COIN_NONE;
         busy     <= 1'b0;
         done     <= 1'b0;
         dropped  <= 1'b0;
      end else begin
         done    <= 1'b0;
         dropped <= d && (st != IDLE);
         case (st)
            IDLE: begin
               if (d) begin
                  rem  <= r;
                  busy <= 1'b1;
                  if (r == '0) begin
                     st   <= DONE;
                     done <= 1'b1;
                  end else begin
                     st <= SEL;
                  end
               end
            end
            SEL: begin
               st       <= REQ;
               coin_req <= 1'b1;
               coin_sel <= pick_c;
            end
            REQ: begin
               if (coin_ack) begin
                  rem      <= rem_next_c;
                  coin_req <= 1'b0;
                  coin_sel <= COIN_NONE;
                  if (rem_next_c == '0) begin
                     st   <= DONE;
                     done <= 1'b1;
                  end else begin
                     st <= SEL;
                  end
               end
            end
            DONE: begin
               st   <= IDLE;
               busy <= 1'b0;
            end
            default: begin
               st       <= IDLE;
               coin_req <= 1'b0;
               coin_sel <= COIN_NONE;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser; expectations follow CHANGE_DISPENSER_FIVE_COIN_EN.
module tb_change_dispenser;

   logic       clk;
   logic       reset;
   logic       d;
   logic [2:0] r;
   logic       coin_ack;
   logic       two_empty;
   logic       five_empty;
   logic       coin_req;
   logic [1:0] coin_sel;
   logic       busy;
   logic       done;
   logic       dropped;
   logic [2:0] rem;
   logic [2:0] state;

   int n_cmp = 0;
   int n_bad = 0;

   logic [1:0] got_coin [8];
   logic [2:0] got_rem  [8];
   logic [2:0] rem0;
   int n_coin, n_rem, done_at, req_cyc, drop_cnt, sel_bad, idle_seen;

   change_dispenser dut (
      .clk        (clk),
      .reset      (reset),
      .d          (d),
      .r          (r),
      .coin_ack   (coin_ack),
      .two_empty  (two_empty),
      .five_empty (five_empty),
      .coin_req   (coin_req),
      .coin_sel   (coin_sel),
      .busy       (busy),
      .done       (done),
      .dropped    (dropped),
      .rem        (rem),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_d(input logic [2:0] val);
      d = 1'b1;
      r = val;
      tick();
      d = 1'b0;
      r = '0;
   endtask

   // Watches one payout starting in the cycle after d; records coins, rem after each ack, done cycle.
   task automatic observe(input int max_cyc, input int ack_wait, input bit inject_d, input bit glitch);
      logic prev_req;
      int   req_cnt;
      bit   injected;
      for (int i = 0; i < 8; i++) begin
         got_coin[i] = 2'bxx;
         got_rem[i]  = 3'bxxx;
      end
      n_coin = 0; n_rem = 0; done_at = -1; req_cyc = 0; drop_cnt = 0; sel_bad = 0; idle_seen = 0;
      prev_req = 1'b0; req_cnt = 0; injected = 1'b0;
      coin_ack = (ack_wait == 0);
      for (int k = 1; k <= max_cyc; k++) begin
         if (k == 1) rem0 = rem;
         if (dropped) drop_cnt++;
         if (!coin_req && coin_sel !== 2'b00) sel_bad++;
         if (!busy) idle_seen++;
         if (coin_req) begin
            req_cyc++;
            if (!prev_req) begin
               if (n_coin < 8) got_coin[n_coin] = coin_sel;
               n_coin++;
               req_cnt = 0;
            end else if (n_coin > 0 && n_coin <= 8 && coin_sel !== got_coin[n_coin-1]) begin
               sel_bad++;
            end
            req_cnt++;
         end else if (prev_req) begin
            if (n_rem < 8) got_rem[n_rem] = rem;
            n_rem++;
         end
         if (done) begin
            done_at = k;
            break;
         end
         d = 1'b0;
         if (inject_d && !injected && coin_req && req_cnt == 1) begin
            d = 1'b1;
            r = 3'd5;
            injected = 1'b1;
         end
         if (glitch && n_coin == 1) two_empty = coin_req && (req_cnt == 2);
         if (ack_wait != 0) coin_ack = coin_req && (req_cnt >= ack_wait);
         prev_req = coin_req;
         tick();
      end
      d = 1'b0;
      r = '0;
      coin_ack = 1'b0;
   endtask

   task automatic test_reset();
      d = 1'b1; r = 3'd5; coin_ack = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (state !== 3'd0)    begin n_bad++; $display("FAIL reset state: got %0d want 0", state); end
      n_cmp++; if (rem !== 3'd0)      begin n_bad++; $display("FAIL reset rem: got %0d want 0", rem); end
      n_cmp++; if (coin_req !== 1'b0) begin n_bad++; $display("FAIL reset coin_req: got %b want 0", coin_req); end
      n_cmp++; if (coin_sel !== 2'b00) begin n_bad++; $display("FAIL reset coin_sel: got %b want 00", coin_sel); end
      n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset done: got %b want 0", done); end
      n_cmp++; if (dropped !== 1'b0)  begin n_bad++; $display("FAIL reset dropped: got %b want 0", dropped); end
      d = 1'b0; r = '0; coin_ack = 1'b0;
      #2 reset = 1'b1;
      tick();
   endtask

   task automatic test_ack_idle();
      coin_ack = 1'b1;
      repeat (3) tick();
      n_cmp++; if (state !== 3'd0 || coin_req !== 1'b0 || busy !== 1'b0)
         begin n_bad++; $display("FAIL ack_idle: got state=%0d req=%b busy=%b want 0/0/0", state, coin_req, busy); end
      coin_ack = 1'b0;
   endtask

   task automatic test_seven();
      logic [1:0] ec [4];
      logic [2:0] er [4];
      int ne, edone;
`ifdef CHANGE_DISPENSER_FIVE_COIN_EN
      ec = '{2'b11, 2'b10, 2'b00, 2'b00}; er = '{3'd2, 3'd0, 3'd0, 3'd0}; ne = 2; edone = 5;
`else
      ec = '{2'b10, 2'b10, 2'b10, 2'b01}; er = '{3'd5, 3'd3, 3'd1, 3'd0}; ne = 4; edone = 9;
`endif
      pulse_d(3'd7);
      observe(30, 0, 1'b0, 1'b0);
      n_cmp++; if (rem0 !== 3'd7) begin n_bad++; $display("FAIL seven rem0: got %0d want 7", rem0); end
      n_cmp++; if (done_at !== edone) begin n_bad++; $display("FAIL seven done_at: got %0d want %0d", done_at, edone); end
      n_cmp++; if (n_coin !== ne) begin n_bad++; $display("FAIL seven n_coin: got %0d want %0d", n_coin, ne); end
      for (int i = 0; i < ne; i++) begin
         n_cmp++; if (got_coin[i] !== ec[i]) begin n_bad++; $display("FAIL seven coin%0d: got %b want %b", i, got_coin[i], ec[i]); end
         n_cmp++; if (got_rem[i] !== er[i]) begin n_bad++; $display("FAIL seven rem%0d: got %0d want %0d", i, got_rem[i], er[i]); end
      end
      n_cmp++; if (sel_bad !== 0 || idle_seen !== 0 || drop_cnt !== 0)
         begin n_bad++; $display("FAIL seven flags: got sel_bad=%0d idle=%0d drop=%0d want 0/0/0", sel_bad, idle_seen, drop_cnt); end
      tick();
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || state !== 3'd0)
         begin n_bad++; $display("FAIL seven after_done: got done=%b busy=%b state=%0d want 0/0/0", done, busy, state); end
   endtask

   task automatic test_two_empty();
      logic [1:0] ec [3];
      logic [2:0] er [3];
      ec = '{2'b01, 2'b01, 2'b01}; er = '{3'd2, 3'd1, 3'd0};
      two_empty = 1'b1;
      pulse_d(3'd3);
      observe(30, 0, 1'b0, 1'b0);
      two_empty = 1'b0;
      n_cmp++; if (done_at !== 7) begin n_bad++; $display("FAIL two_empty done_at: got %0d want 7", done_at); end
      n_cmp++; if (n_coin !== 3) begin n_bad++; $display("FAIL two_empty n_coin: got %0d want 3", n_coin); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (got_coin[i] !== ec[i]) begin n_bad++; $display("FAIL two_empty coin%0d: got %b want %b", i, got_coin[i], ec[i]); end
         n_cmp++; if (got_rem[i] !== er[i]) begin n_bad++; $display("FAIL two_empty rem%0d: got %0d want %0d", i, got_rem[i], er[i]); end
      end
      tick();
   endtask

   task automatic test_zero();
      pulse_d(3'd0);
      observe(10, 0, 1'b0, 1'b0);
      n_cmp++; if (done_at !== 1) begin n_bad++; $display("FAIL zero done_at: got %0d want 1", done_at); end
      n_cmp++; if (req_cyc !== 0) begin n_bad++; $display("FAIL zero req_cyc: got %0d want 0", req_cyc); end
      tick();
      n_cmp++; if (done !== 1'b0 || state !== 3'd0)
         begin n_bad++; $display("FAIL zero pulse_width: got done=%b state=%0d want 0/0", done, state); end
   endtask

   task automatic test_five();
      logic [1:0] ec [3];
      logic [2:0] er [3];
      int ne, edone;
      ec = '{2'b10, 2'b10, 2'b01}; er = '{3'd3, 3'd1, 3'd0};
      five_empty = 1'b1;
      pulse_d(3'd5);
      observe(30, 0, 1'b0, 1'b0);
      five_empty = 1'b0;
      n_cmp++; if (done_at !== 7) begin n_bad++; $display("FAIL five_empty done_at: got %0d want 7", done_at); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (got_coin[i] !== ec[i]) begin n_bad++; $display("FAIL five_empty coin%0d: got %b want %b", i, got_coin[i], ec[i]); end
         n_cmp++; if (got_rem[i] !== er[i]) begin n_bad++; $display("FAIL five_empty rem%0d: got %0d want %0d", i, got_rem[i], er[i]); end
      end
      tick();
`ifdef CHANGE_DISPENSER_FIVE_COIN_EN
      ec = '{2'b11, 2'b00, 2'b00}; er = '{3'd0, 3'd0, 3'd0}; ne = 1; edone = 3;
`else
      ne = 3; edone = 7;
`endif
      pulse_d(3'd5);
      observe(30, 0, 1'b0, 1'b0);
      n_cmp++; if (done_at !== edone) begin n_bad++; $display("FAIL five done_at: got %0d want %0d", done_at, edone); end
      n_cmp++; if (n_coin !== ne) begin n_bad++; $display("FAIL five n_coin: got %0d want %0d", n_coin, ne); end
      for (int i = 0; i < ne; i++) begin
         n_cmp++; if (got_coin[i] !== ec[i]) begin n_bad++; $display("FAIL five coin%0d: got %b want %b", i, got_coin[i], ec[i]); end
      end
      tick();
   endtask

   task automatic test_slow_ack();
      pulse_d(3'd4);
      observe(40, 3, 1'b1, 1'b1);
      n_cmp++; if (done_at !== 9) begin n_bad++; $display("FAIL slow_ack done_at: got %0d want 9", done_at); end
      n_cmp++; if (req_cyc !== 6) begin n_bad++; $display("FAIL slow_ack req_cyc: got %0d want 6", req_cyc); end
      n_cmp++; if (drop_cnt !== 1) begin n_bad++; $display("FAIL slow_ack dropped: got %0d want 1", drop_cnt); end
      n_cmp++; if (sel_bad !== 0) begin n_bad++; $display("FAIL slow_ack sel_stable: got %0d want 0", sel_bad); end
      n_cmp++; if (got_coin[0] !== 2'b10 || got_coin[1] !== 2'b10)
         begin n_bad++; $display("FAIL slow_ack coins: got %b %b want 10 10", got_coin[0], got_coin[1]); end
      n_cmp++; if (got_rem[0] !== 3'd2 || got_rem[1] !== 3'd0)
         begin n_bad++; $display("FAIL slow_ack rem: got %0d %0d want 2 0", got_rem[0], got_rem[1]); end
      tick();
   endtask

   task automatic test_back_to_back();
      pulse_d(3'd0);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b done: got %b want 1", done); end
      d = 1'b1; r = 3'd3;
      tick();
      d = 1'b0; r = '0;
      n_cmp++; if (dropped !== 1'b1 || state !== 3'd0 || rem !== 3'd0)
         begin n_bad++; $display("FAIL b2b drop_in_done: got dropped=%b state=%0d rem=%0d want 1/0/0", dropped, state, rem); end
      pulse_d(3'd2);
      observe(10, 0, 1'b0, 1'b0);
      n_cmp++; if (done_at !== 3 || got_coin[0] !== 2'b10 || got_rem[0] !== 3'd0)
         begin n_bad++; $display("FAIL b2b second: got done_at=%0d coin=%b rem=%0d want 3/10/0", done_at, got_coin[0], got_rem[0]); end
      tick();
   endtask

   task automatic test_reset_mid();
      coin_ack = 1'b0;
      pulse_d(3'd2);
      tick();
      n_cmp++; if (state !== 3'd2 || coin_req !== 1'b1 || coin_sel !== 2'b10 || rem !== 3'd2)
         begin n_bad++; $display("FAIL rst_mid in_req: got state=%0d req=%b sel=%b rem=%0d want 2/1/10/2", state, coin_req, coin_sel, rem); end
      #2 reset = 1'b0;
      #1;
      n_cmp++; if (state !== 3'd0 || rem !== 3'd0 || coin_req !== 1'b0 || coin_sel !== 2'b00)
         begin n_bad++; $display("FAIL rst_mid async: got state=%0d rem=%0d req=%b sel=%b want 0/0/0/00", state, rem, coin_req, coin_sel); end
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || dropped !== 1'b0)
         begin n_bad++; $display("FAIL rst_mid flags: got busy=%b done=%b dropped=%b want 0/0/0", busy, done, dropped); end
      d = 1'b1; r = 3'd3; coin_ack = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (state !== 3'd0 || busy !== 1'b0 || done !== 1'b0)
         begin n_bad++; $display("FAIL rst_mid held: got state=%0d busy=%b done=%b want 0/0/0", state, busy, done); end
      d = 1'b0; r = '0; coin_ack = 1'b0;
      reset = 1'b1;
      pulse_d(3'd1);
      n_cmp++; if (state !== 3'd1 || rem !== 3'd1)
         begin n_bad++; $display("FAIL rst_mid first_edge: got state=%0d rem=%0d want 1/1", state, rem); end
      observe(10, 0, 1'b0, 1'b0);
      n_cmp++; if (done_at !== 3 || n_coin !== 1 || got_coin[0] !== 2'b01 || got_rem[0] !== 3'd0)
         begin n_bad++; $display("FAIL rst_mid resume: got done_at=%0d n=%0d coin=%b rem=%0d want 3/1/01/0", done_at, n_coin, got_coin[0], got_rem[0]); end
      tick();
   endtask

   initial begin
      reset = 1'b0; d = 1'b0; r = '0; coin_ack = 1'b0; two_empty = 1'b0; five_empty = 1'b0;
      test_reset();
      test_ack_idle();
      test_seven();
      test_two_empty();
      test_zero();
      test_five();
      test_slow_ack();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
